// File: rtl/vga_sync_gen_module.sv
// VGA timing generator: free-running h/v counters, active-area pixel
// coordinates, frame-start pulse and polarity-configurable sync outputs
// with an optional extra delay so they line up with a downstream ROM lookup.
// Optional colour-bar test pattern on tp_* when VGA_TEST_PATTERN_EN is defined.
module vga_sync_gen_module #(
    parameter int H_SYNC     = 120,
    parameter int H_BP       = 64,
    parameter int H_ACTIVE   = 800,
    parameter int H_FP       = 56,
    parameter int V_SYNC     = 6,
    parameter int V_BP       = 23,
    parameter int V_ACTIVE   = 600,
    parameter int V_FP       = 37,
    parameter int HSYNC_POL  = 1,
    parameter int VSYNC_POL  = 1,
    parameter int SYNC_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [10:0] col_addr_sig,
    output logic [10:0] row_addr_sig,
    output logic        ready_sig,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic        tp_red,
    output logic        tp_green,
    output logic        tp_blue
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_START   = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_END     = 11'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [10:0] V_START   = 11'(V_SYNC + V_BP);
    localparam logic [10:0] V_END     = 11'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [10:0] H_SYNC_LN = 11'(H_SYNC);
    localparam logic [10:0] V_SYNC_LN = 11'(V_SYNC);

    // Level driven while the corresponding sync is asserted.
    localparam logic HS_ON = (HSYNC_POL != 0);
    localparam logic VS_ON = (VSYNC_POL != 0);

    logic [10:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic [10:0] col_addr_q, col_addr_d;
    logic [10:0] row_addr_q, row_addr_d;
    logic        ready_q, ready_d;
    logic        frame_start_q, frame_start_d;

    // Stage 0 is the first registered copy; stage SYNC_DELAY drives the pin.
    logic [SYNC_DELAY:0] hs_pipe_q, hs_pipe_d;
    logic [SYNC_DELAY:0] vs_pipe_q, vs_pipe_d;

    // Counter advance: h wraps every line, v steps on h wrap and wraps with it.
    always_comb begin
        h_cnt_d = h_cnt_q + 11'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? 11'd0 : v_cnt_q + 11'd1;
        end
    end

    // Active-area qualifier, coordinates and frame-start from current counts.
    always_comb begin
        ready_d       = (h_cnt_q >= H_START) && (h_cnt_q < H_END) &&
                        (v_cnt_q >= V_START) && (v_cnt_q < V_END);
        col_addr_d    = ready_d ? (h_cnt_q - H_START) : 11'd0;
        row_addr_d    = ready_d ? (v_cnt_q - V_START) : 11'd0;
        frame_start_d = (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);
    end

    // Sync shift registers: polarity applied at entry so every stage resets inactive.
    always_comb begin
        hs_pipe_d    = hs_pipe_q;
        vs_pipe_d    = vs_pipe_q;
        hs_pipe_d[0] = (h_cnt_q < H_SYNC_LN) ? HS_ON : ~HS_ON;
        vs_pipe_d[0] = (v_cnt_q < V_SYNC_LN) ? VS_ON : ~VS_ON;
        for (int i = 1; i <= SYNC_DELAY; i++) begin
            hs_pipe_d[i] = hs_pipe_q[i-1];
            vs_pipe_d[i] = vs_pipe_q[i-1];
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            col_addr_q    <= '0;
            row_addr_q    <= '0;
            ready_q       <= 1'b0;
            frame_start_q <= 1'b0;
            hs_pipe_q     <= {(SYNC_DELAY+1){~HS_ON}};
            vs_pipe_q     <= {(SYNC_DELAY+1){~VS_ON}};
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            col_addr_q    <= col_addr_d;
            row_addr_q    <= row_addr_d;
            ready_q       <= ready_d;
            frame_start_q <= frame_start_d;
            hs_pipe_q     <= hs_pipe_d;
            vs_pipe_q     <= vs_pipe_d;
        end
    end

    assign col_addr_sig = col_addr_q;
    assign row_addr_sig = row_addr_q;
    assign ready_sig    = ready_q;
    assign frame_start  = frame_start_q;
    assign hsync        = hs_pipe_q[SYNC_DELAY];
    assign vsync        = vs_pipe_q[SYNC_DELAY];

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);

    logic [10:0] bar;
    logic [2:0]  tp_q, tp_d;

    // Eight vertical colour bars across the active width, black in blanking.
    always_comb begin
        bar  = col_addr_d / BAR_W;
        tp_d = ready_d ? 3'(bar) : 3'b000;
    end

    // Pattern register, same latency as ready_sig.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tp_q <= 3'b000;
        end else begin
            tp_q <= tp_d;
        end
    end

    assign tp_red   = tp_q[2];
    assign tp_green = tp_q[1];
    assign tp_blue  = tp_q[0];
`else
    assign tp_red   = 1'b0;
    assign tp_green = 1'b0;
    assign tp_blue  = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_gen_module.sv
// Bench for vga_sync_gen_module using a reduced timing (25 clocks x 9 lines)
// so full frames fit in a short run. Two instances share clk/rst_n:
// u_dut1 with SYNC_DELAY=1 and active-high syncs, u_dut0 with SYNC_DELAY=0
// and active-low syncs.
module tb_vga_sync_gen_module;

    localparam int HS = 4, HB = 3, HA = 16, HF = 2;
    localparam int VS = 2, VB = 2, VA = 4, VF = 1;
    localparam int HT = HS + HB + HA + HF;   // 25
    localparam int VT = VS + VB + VA + VF;   // 9

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic [10:0] d1_col, d1_row, d0_col, d0_row;
    logic        d1_ready, d1_fs, d1_hs, d1_vs, d1_r, d1_g, d1_b;
    logic        d0_ready, d0_fs, d0_hs, d0_vs, d0_r, d0_g, d0_b;

    int n;        // rising edges since the last reset release
    int checks;
    int fails;

    vga_sync_gen_module #(
        .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
        .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
        .HSYNC_POL(1), .VSYNC_POL(1), .SYNC_DELAY(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .col_addr_sig(d1_col), .row_addr_sig(d1_row), .ready_sig(d1_ready),
        .frame_start(d1_fs), .hsync(d1_hs), .vsync(d1_vs),
        .tp_red(d1_r), .tp_green(d1_g), .tp_blue(d1_b)
    );

    vga_sync_gen_module #(
        .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
        .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
        .HSYNC_POL(0), .VSYNC_POL(0), .SYNC_DELAY(0)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .col_addr_sig(d0_col), .row_addr_sig(d0_row), .ready_sig(d0_ready),
        .frame_start(d0_fs), .hsync(d0_hs), .vsync(d0_vs),
        .tp_red(d0_r), .tp_green(d0_g), .tp_blue(d0_b)
    );

    always #5 clk = ~clk;

    // Expected {ready,col,row,fs,hsync,vsync,rgb} after rising edge 'en'
    // following release, derived from absolute time since release.
    function automatic logic [28:0] exp_vec(int en, int d, logic pol);
        logic        rdy, fs, hs, vs;
        logic [10:0] col, row;
        logic [2:0]  tp;
        int k, h, v, ks;
        if (en <= 0) return {1'b0, 11'd0, 11'd0, 1'b0, ~pol, ~pol, 3'b000};
        k   = en - 1;
        h   = k % HT;
        v   = (k / HT) % VT;
        rdy = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
        col = rdy ? 11'(h - (HS + HB)) : 11'd0;
        row = rdy ? 11'(v - (VS + VB)) : 11'd0;
        fs  = (h == 0) && (v == 0);
        ks  = k - d;
        if (ks < 0) begin
            hs = ~pol;
            vs = ~pol;
        end else begin
            hs = ((ks % HT) < HS) ? pol : ~pol;
            vs = (((ks / HT) % VT) < VS) ? pol : ~pol;
        end
`ifdef VGA_TEST_PATTERN_EN
        tp = rdy ? 3'(col / 11'(HA / 8)) : 3'b000;
`else
        tp = 3'b000;
`endif
        return {rdy, col, row, fs, hs, vs, tp};
    endfunction

    task automatic step();
        @(posedge clk);
        n = n + 1;
        #1;
    endtask

    task automatic step_to(int t);
        while (n < t) step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
    endtask

    // Compare both instances against the timing model for 'edges' clocks.
    task automatic scan(string tag, int edges);
        logic [28:0] e1, e0, a1, a0;
        int f0;
        f0 = fails;
        for (int i = 0; i < edges; i++) begin
            step();
            e1 = exp_vec(n, 1, 1'b1);
            e0 = exp_vec(n, 0, 1'b0);
            a1 = {d1_ready, d1_col, d1_row, d1_fs, d1_hs, d1_vs, d1_r, d1_g, d1_b};
            a0 = {d0_ready, d0_col, d0_row, d0_fs, d0_hs, d0_vs, d0_r, d0_g, d0_b};
            checks++;
            if (a1 !== e1) begin
                fails++;
                $display("FAIL %s_dut1 edge %0d: got %h required %h", tag, n, a1, e1);
            end
            checks++;
            if (a0 !== e0) begin
                fails++;
                $display("FAIL %s_dut0 edge %0d: got %h required %h", tag, n, a0, e0);
            end
        end
        $display("scan %s: %0d edges, %0d new failures", tag, edges, fails - f0);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({d1_ready, d1_col, d1_row, d1_fs, d1_hs, d1_vs, d1_r, d1_g, d1_b} !== 29'd0) begin
            fails++;
            $display("FAIL reset_dut1: got %h required 0", {d1_ready, d1_col, d1_row, d1_fs, d1_hs, d1_vs});
        end
        checks++;
        if ({d0_ready, d0_col, d0_row, d0_fs, d0_hs, d0_vs, d0_r, d0_g, d0_b} !== 29'b0_00000000000_00000000000_0_1_1_000) begin
            fails++;
            $display("FAIL reset_dut0: got %h required 000000018", {d0_ready, d0_col, d0_row, d0_fs, d0_hs, d0_vs, d0_r, d0_g, d0_b});
        end
        $display("test_reset done");
        rst_n = 1'b1;
        n = 0;
    endtask

    task automatic test_timing();
        do_reset();
        step_to(1);
        checks++;
        if ({d1_fs, d1_hs, d0_hs, d1_ready} !== 4'b1000) begin
            fails++; $display("FAIL edge1 {fs,hs1,hs0,rdy}: got %b required 1000", {d1_fs, d1_hs, d0_hs, d1_ready});
        end
        step_to(2);
        checks++;
        if ({d1_fs, d1_hs, d1_vs} !== 3'b011) begin
            fails++; $display("FAIL edge2 hs_vs_lead: got %b required 011", {d1_fs, d1_hs, d1_vs});
        end
        step_to(5);
        checks++;
        if ({d1_hs, d0_hs} !== 2'b11) begin
            fails++; $display("FAIL edge5 hsync: got %b required 11", {d1_hs, d0_hs});
        end
        step_to(6);
        checks++;
        if (d1_hs !== 1'b0) begin
            fails++; $display("FAIL edge6 hsync_end: got %b required 0", d1_hs);
        end
        step_to(27);
        checks++;
        if (d1_hs !== 1'b1) begin
            fails++; $display("FAIL edge27 hsync_line2: got %b required 1", d1_hs);
        end
        step_to(50);
        checks++;
        if ({d1_vs, d0_vs} !== 2'b10) begin
            fails++; $display("FAIL edge50 vsync: got %b required 10", {d1_vs, d0_vs});
        end
        step_to(52);
        checks++;
        if ({d1_vs, d0_vs} !== 2'b01) begin
            fails++; $display("FAIL edge52 vsync_end: got %b required 01", {d1_vs, d0_vs});
        end
        step_to(107);
        checks++;
        if (d1_ready !== 1'b0) begin
            fails++; $display("FAIL edge107 ready_early: got %b required 0", d1_ready);
        end
        step_to(108);
        checks++;
        if ({d1_ready, d1_col, d1_row} !== {1'b1, 11'd0, 11'd0}) begin
            fails++; $display("FAIL edge108 first_pixel: got %b/%0d/%0d required 1/0/0", d1_ready, d1_col, d1_row);
        end
        step_to(123);
        checks++;
        if ({d1_ready, d1_col, d1_row} !== {1'b1, 11'd15, 11'd0}) begin
            fails++; $display("FAIL edge123 line_end: got %b/%0d/%0d required 1/15/0", d1_ready, d1_col, d1_row);
        end
        step_to(124);
        checks++;
        if ({d1_ready, d1_col} !== {1'b0, 11'd0}) begin
            fails++; $display("FAIL edge124 blank: got %b/%0d required 0/0", d1_ready, d1_col);
        end
        step_to(198);
        checks++;
        if ({d1_ready, d1_col, d1_row} !== {1'b1, 11'd15, 11'd3}) begin
            fails++; $display("FAIL edge198 last_pixel: got %b/%0d/%0d required 1/15/3", d1_ready, d1_col, d1_row);
        end
        step_to(199);
        checks++;
        if ({d1_ready, d1_row} !== {1'b0, 11'd0}) begin
            fails++; $display("FAIL edge199 after_last: got %b/%0d required 0/0", d1_ready, d1_row);
        end
        step_to(225);
        checks++;
        if (d1_fs !== 1'b0) begin
            fails++; $display("FAIL edge225 fs_early: got %b required 0", d1_fs);
        end
        step_to(226);
        checks++;
        if ({d1_fs, d0_fs} !== 2'b11) begin
            fails++; $display("FAIL edge226 fs_frame2: got %b required 11", {d1_fs, d0_fs});
        end
        step_to(227);
        checks++;
        if ({d1_fs, d1_hs, d1_vs} !== 3'b011) begin
            fails++; $display("FAIL edge227 frame2_sync_lead: got %b required 011", {d1_fs, d1_hs, d1_vs});
        end
        $display("test_timing done");
    endtask

    task automatic test_frames();
        do_reset();
        scan("frames", 2 * HT * VT + 10);
    endtask

    task automatic test_mid_reset();
        do_reset();
        step_to(3 * HT + 5 * HT - 3 * HT + 12 + 1);   // counters at h=12, v=5 after this edge
        rst_n = 1'b0;
        #1;
        checks++;
        if ({d1_ready, d1_col, d1_row, d1_fs, d1_hs, d1_vs} !== 26'd0) begin
            fails++; $display("FAIL midreset_dut1: got %h required 0", {d1_ready, d1_col, d1_row, d1_fs, d1_hs, d1_vs});
        end
        checks++;
        if ({d0_ready, d0_col, d0_row, d0_fs, d0_hs, d0_vs} !== 26'b11) begin
            fails++; $display("FAIL midreset_dut0: got %h required 3", {d0_ready, d0_col, d0_row, d0_fs, d0_hs, d0_vs});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        scan("after_midreset", HT * VT + 5);
    endtask

    task automatic test_pattern();
        logic [2:0] e_a, e_b, e_c, e_d;
`ifdef VGA_TEST_PATTERN_EN
        e_a = 3'b000; e_b = 3'b001; e_c = 3'b111; e_d = 3'b000;
`else
        e_a = 3'b000; e_b = 3'b000; e_c = 3'b000; e_d = 3'b000;
`endif
        do_reset();
        step_to(109);   // col 1
        checks++;
        if ({d1_r, d1_g, d1_b} !== e_a) begin
            fails++; $display("FAIL tp_col1: got %b required %b", {d1_r, d1_g, d1_b}, e_a);
        end
        step_to(110);   // col 2
        checks++;
        if ({d1_r, d1_g, d1_b} !== e_b) begin
            fails++; $display("FAIL tp_col2: got %b required %b", {d1_r, d1_g, d1_b}, e_b);
        end
        step_to(123);   // col 15
        checks++;
        if ({d0_r, d0_g, d0_b} !== e_c) begin
            fails++; $display("FAIL tp_col15: got %b required %b", {d0_r, d0_g, d0_b}, e_c);
        end
        step_to(124);   // blanking
        checks++;
        if ({d1_r, d1_g, d1_b} !== e_d) begin
            fails++; $display("FAIL tp_blank: got %b required %b", {d1_r, d1_g, d1_b}, e_d);
        end
        $display("test_pattern done");
    endtask

    initial begin
        n = 0;
        checks = 0;
        fails = 0;
        test_reset();
        test_timing();
        test_frames();
        test_mid_reset();
        test_pattern();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
